vector_writeback: RTL and testbench

Result-side sequencer for the vector unit: accepts per-cycle results from the vector ALU and writes them into the vector register file, one register of a register group per accepted beat. It generates byte enables from vl, vsew and the v0 mask so that tail and masked-off elements are left undisturbed. For compare-style instructions it collapses the beats into a single mask-register write. It sits between the vector ALU's result_o / result_mask_o / hold_o outputs and the VRF write port.

---
 rtl/vector_writeback.sv | 194 +++++++++++++++++++
 tb/tb_vector_writeback.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback.sv
// vector_writeback: result-side sequencer between the vector ALU and the VRF
// write port. Each accepted ALU beat becomes one register write of the
// destination group, with byte enables built from vl, vsew and the v0 mask so
// tail and masked-off elements stay undisturbed.
// Optional feature macro VWB_MASK_WB_EN: when defined, compare-style
// instructions (mask_result_i=1) collapse their beats into one mask-register
// write issued from the MASK_WB state. When undefined, every instruction
// takes the data-write path and mask_result_i / result_mask_i are ignored.
module vector_writeback #(
    parameter int VLEN  = 64,
    parameter int VLENB = VLEN / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [4:0]            vd_i,
    input  logic [3:0]            nregs_i,
    input  logic [1:0]            vsew_i,
    input  logic [$clog2(VLEN):0] vl_i,
    input  logic                  vm_i,
    input  logic [VLEN-1:0]       mask_i,
    input  logic                  mask_result_i,
    input  logic                  result_valid_i,
    input  logic                  hold_i,
    input  logic [VLEN-1:0]       result_i,
    input  logic [VLEN-1:0]       result_mask_i,
    output logic                  wr_en_o,
    output logic [4:0]            wr_addr_o,
    output logic [VLEN-1:0]       wr_data_o,
    output logic [VLENB-1:0]      wr_be_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int VLW = $clog2(VLEN) + 1;

    // WRITE keeps one extra cycle with cnt == nregs after the last data beat
    // so that done_o lands the cycle after the final write; MASK_WB plays the
    // same role for the mask write, which is launched as the last beat lands.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
`ifdef VWB_MASK_WB_EN
        MASK_WB = 2'd2,
`endif
        DONE    = 2'd3
    } state_t;

    state_t state, state_n;

    logic [3:0]       cnt, cnt_n;
    logic [4:0]       vd_q;
    logic [3:0]       nregs_q;
    logic [1:0]       vsew_q;
    logic [VLW-1:0]   vl_q;
    logic             vm_q;
    logic [VLEN-1:0]  mask_q;
    logic             mask_mode;

    logic             wr_en_n;
    logic [4:0]       wr_addr_n;
    logic [VLEN-1:0]  wr_data_n;
    logic [VLENB-1:0] wr_be_n;
    logic [VLENB-1:0] beat_be_v;
    logic             accept;
    logic             last_beat;

    // Byte enables for one beat: byte b of beat k holds element
    // (k*VLENB + b) >> sew; enabled when inside vl and not masked off.
    function automatic logic [VLENB-1:0] beat_be(
        input logic [3:0]      beat,
        input logic [1:0]      sew,
        input logic [VLW-1:0]  vl,
        input logic            vm,
        input logic [VLEN-1:0] mask
    );
        logic [VLW-1:0] byte_idx;
        logic [VLW-1:0] elem;
        beat_be = '0;
        for (int b = 0; b < VLENB; b++) begin
            byte_idx   = VLW'(beat) * VLW'(VLENB) + VLW'(b);
            elem       = byte_idx >> sew;
            beat_be[b] = (elem < vl) && (vm || mask[elem[VLW-2:0]]);
        end
    endfunction

`ifdef VWB_MASK_WB_EN
    logic mask_result_q;
    assign mask_mode = mask_result_q;

    // Mask-register image: body bits from the ALU, tail bits forced to one.
    function automatic logic [VLEN-1:0] mask_data(
        input logic [VLEN-1:0] rm,
        input logic [VLW-1:0]  vl
    );
        for (int e = 0; e < VLEN; e++) begin
            mask_data[e] = (VLW'(e) < vl) ? rm[e] : 1'b1;
        end
    endfunction
`else
    logic unused_mask_inputs;
    assign mask_mode          = 1'b0;
    assign unused_mask_inputs = ^{mask_result_i, result_mask_i};
`endif

    assign accept    = (state == WRITE) && (cnt != nregs_q) && result_valid_i && !hold_i;
    assign last_beat = (cnt == nregs_q - 4'd1);
    assign beat_be_v = beat_be(cnt, vsew_q, vl_q, vm_q, mask_q);

    // Next state, beat counter and next values of the registered write port.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_o;
        wr_data_n = wr_data_o;
        wr_be_n   = wr_be_o;
        case (state)
            IDLE: begin
                if (start_i) begin
                    cnt_n   = '0;
                    state_n = (vl_i == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    cnt_n = cnt + 4'd1;
                    if (mask_mode) begin
`ifdef VWB_MASK_WB_EN
                        if (last_beat) begin
                            state_n   = MASK_WB;
                            wr_en_n   = 1'b1;
                            wr_addr_n = vd_q;
                            wr_data_n = mask_data(result_mask_i, vl_q);
                            wr_be_n   = '1;
                        end
`endif
                    end else begin
                        wr_en_n   = |beat_be_v;
                        wr_addr_n = vd_q + 5'(cnt);
                        wr_data_n = result_i;
                        wr_be_n   = beat_be_v;
                    end
                end else if (cnt == nregs_q) begin
                    state_n = DONE;
                end
            end
`ifdef VWB_MASK_WB_EN
            MASK_WB: state_n = DONE;
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, counter and all outputs; reset abandons any partial group.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            wr_be_o   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wr_en_o   <= wr_en_n;
            wr_addr_o <= wr_addr_n;
            wr_data_o <= wr_data_n;
            wr_be_o   <= wr_be_n;
            busy_o    <= (state_n != IDLE);
            done_o    <= (state_n == DONE);
        end
    end

    // Instruction parameters captured when a new writeback starts.
    always_ff @(posedge clk) begin
        if (state == IDLE && start_i) begin
            vd_q          <= vd_i;
            nregs_q       <= nregs_i;
            vsew_q        <= vsew_i;
            vl_q          <= vl_i;
            vm_q          <= vm_i;
            mask_q        <= mask_i;
`ifdef VWB_MASK_WB_EN
            mask_result_q <= mask_result_i;
`endif
        end
    end

endmodule

// File: tb/tb_vector_writeback.sv
// Directed testbench for vector_writeback (VLEN=64). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_vector_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [4:0]  vd_i;
    logic [3:0]  nregs_i;
    logic [1:0]  vsew_i;
    logic [6:0]  vl_i;
    logic        vm_i;
    logic [63:0] mask_i;
    logic        mask_result_i;
    logic        result_valid_i;
    logic        hold_i;
    logic [63:0] result_i;
    logic [63:0] result_mask_i;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [63:0] wr_data_o;
    logic [7:0]  wr_be_o;
    logic        busy_o;
    logic        done_o;

    int vectors     = 0;
    int miscompares = 0;

    vector_writeback #(.VLEN(64), .VLENB(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_i        (start_i),
        .vd_i           (vd_i),
        .nregs_i        (nregs_i),
        .vsew_i         (vsew_i),
        .vl_i           (vl_i),
        .vm_i           (vm_i),
        .mask_i         (mask_i),
        .mask_result_i  (mask_result_i),
        .result_valid_i (result_valid_i),
        .hold_i         (hold_i),
        .result_i       (result_i),
        .result_mask_i  (result_mask_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .wr_be_o        (wr_be_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [4:0] vd, input logic [3:0] nr, input logic [1:0] sew,
                            input logic [6:0] vl, input logic vm, input logic [63:0] mask,
                            input logic mres);
        vd_i = vd; nregs_i = nr; vsew_i = sew; vl_i = vl; vm_i = vm;
        mask_i = mask; mask_result_i = mres; start_i = 1'b1;
        tick;
        start_i = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic [63:0] rm);
        result_valid_i = 1'b1; hold_i = 1'b0; result_i = d; result_mask_i = rm;
        tick;
        result_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick; tick;
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_data_o, wr_be_o, busy_o, done_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got en=%b addr=%0d data=%h be=%h busy=%b done=%b, want all 0",
                     wr_en_o, wr_addr_o, wr_data_o, wr_be_o, busy_o, done_o);
        end
        reset_n = 1'b1;
        tick;
        vectors++;
        if ({wr_en_o, busy_o, done_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got en=%b busy=%b done=%b, want 000", wr_en_o, busy_o, done_o);
        end
    endtask

    task automatic test_basic;
        do_start(5'd4, 4'd1, 2'd2, 7'd2, 1'b1, 64'h0, 1'b0);
        vectors++;
        if ({busy_o, wr_en_o, done_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_busy_rise: got busy=%b en=%b done=%b, want 1 0 0", busy_o, wr_en_o, done_o);
        end
        beat(64'h1122334455667788, 64'h0);
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd4, 8'hFF} || wr_data_o !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL basic_write: got en=%b addr=%0d be=%h data=%h, want en=1 addr=4 be=ff data=1122334455667788",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        tick;
        vectors++;
        if ({done_o, busy_o, wr_en_o} !== 3'b110) begin
            miscompares++;
            $display("FAIL basic_done: got done=%b busy=%b en=%b, want 1 1 0", done_o, busy_o, wr_en_o);
        end
        tick;
        vectors++;
        if ({done_o, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_idle: got done=%b busy=%b, want 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_sew16;
        do_start(5'd2, 4'd1, 2'd1, 7'd3, 1'b1, 64'h0, 1'b0);
        beat(64'hA5A5A5A5A5A5A5A5, 64'h0);
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd2, 8'h3F}) begin
            miscompares++;
            $display("FAIL sew16_be: got en=%b addr=%0d be=%h, want en=1 addr=2 be=3f", wr_en_o, wr_addr_o, wr_be_o);
        end
        tick; tick;
    endtask

    task automatic test_hold;
        do_start(5'd6, 4'd2, 2'd0, 7'd10, 1'b1, 64'h0, 1'b0);
        beat(64'h0101010101010101, 64'h0);
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd6, 8'hFF}) begin
            miscompares++;
            $display("FAIL hold_beat0: got en=%b addr=%0d be=%h, want en=1 addr=6 be=ff", wr_en_o, wr_addr_o, wr_be_o);
        end
        result_valid_i = 1'b1; hold_i = 1'b1; result_i = 64'h0202020202020202;
        for (int i = 0; i < 2; i++) begin
            tick;
            vectors++;
            if ({wr_en_o, busy_o, done_o} !== 3'b010) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got en=%b busy=%b done=%b, want 0 1 0", i, wr_en_o, busy_o, done_o);
            end
        end
        hold_i = 1'b0;
        tick;
        result_valid_i = 1'b0;
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd7, 8'h03} || wr_data_o !== 64'h0202020202020202) begin
            miscompares++;
            $display("FAIL hold_beat1: got en=%b addr=%0d be=%h data=%h, want en=1 addr=7 be=03 data=0202020202020202",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        tick;
        vectors++;
        if ({done_o, wr_en_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL hold_done: got done=%b en=%b, want 1 0", done_o, wr_en_o);
        end
        tick;
    endtask

    task automatic test_masked;
        do_start(5'd9, 4'd1, 2'd2, 7'd2, 1'b0, 64'h1, 1'b0);
        beat(64'hDEADBEEFCAFEF00D, 64'h0);
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd9, 8'h0F}) begin
            miscompares++;
            $display("FAIL masked_be: got en=%b addr=%0d be=%h, want en=1 addr=9 be=0f", wr_en_o, wr_addr_o, wr_be_o);
        end
        tick; tick;
        do_start(5'd9, 4'd1, 2'd2, 7'd2, 1'b0, 64'h0, 1'b0);
        beat(64'hDEADBEEFCAFEF00D, 64'h0);
        vectors++;
        if (wr_en_o !== 1'b0) begin
            miscompares++;
            $display("FAIL all_masked_no_write: got en=%b, want 0", wr_en_o);
        end
        tick;
        vectors++;
        if ({done_o, wr_en_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL all_masked_done: got done=%b en=%b, want 1 0", done_o, wr_en_o);
        end
        tick;
    endtask

    task automatic test_mask_result;
        do_start(5'd0, 4'd2, 2'd2, 7'd5, 1'b1, 64'h0, 1'b1);
        beat(64'h1111111111111111, 64'h0A);
`ifdef VWB_MASK_WB_EN
        vectors++;
        if (wr_en_o !== 1'b0) begin
            miscompares++;
            $display("FAIL maskres_beat0_nowrite: got en=%b, want 0", wr_en_o);
        end
        beat(64'h2222222222222222, 64'h0A);
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd0, 8'hFF} || wr_data_o !== 64'hFFFFFFFFFFFFFFEA) begin
            miscompares++;
            $display("FAIL maskres_write: got en=%b addr=%0d be=%h data=%h, want en=1 addr=0 be=ff data=ffffffffffffffea",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
`else
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd0, 8'hFF} || wr_data_o !== 64'h1111111111111111) begin
            miscompares++;
            $display("FAIL maskres_data0: got en=%b addr=%0d be=%h data=%h, want en=1 addr=0 be=ff data=1111111111111111",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        beat(64'h2222222222222222, 64'h0A);
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd1, 8'hFF} || wr_data_o !== 64'h2222222222222222) begin
            miscompares++;
            $display("FAIL maskres_data1: got en=%b addr=%0d be=%h data=%h, want en=1 addr=1 be=ff data=2222222222222222",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
`endif
        tick;
        vectors++;
        if ({done_o, wr_en_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL maskres_done: got done=%b en=%b, want 1 0", done_o, wr_en_o);
        end
        tick;
    endtask

    task automatic test_vl_zero;
        do_start(5'd3, 4'd1, 2'd2, 7'd0, 1'b1, 64'h0, 1'b0);
        vectors++;
        if ({done_o, wr_en_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL vl0_done: got done=%b en=%b, want 1 0", done_o, wr_en_o);
        end
        tick;
        vectors++;
        if ({done_o, busy_o, wr_en_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL vl0_idle: got done=%b busy=%b en=%b, want 0 0 0", done_o, busy_o, wr_en_o);
        end
    endtask

    task automatic test_back_to_back;
        do_start(5'd31, 4'd2, 2'd0, 7'd16, 1'b1, 64'h0, 1'b0);
        result_valid_i = 1'b1; hold_i = 1'b0; result_i = 64'h3333333333333333;
        start_i = 1'b1; vd_i = 5'd5;
        tick;
        start_i = 1'b0;
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd31, 8'hFF} || wr_data_o !== 64'h3333333333333333) begin
            miscompares++;
            $display("FAIL b2b_first: got en=%b addr=%0d be=%h data=%h, want en=1 addr=31 be=ff data=3333333333333333",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        result_i = 64'h4444444444444444;
        tick;
        result_valid_i = 1'b0;
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd0, 8'hFF} || wr_data_o !== 64'h4444444444444444) begin
            miscompares++;
            $display("FAIL b2b_wrap: got en=%b addr=%0d be=%h data=%h, want en=1 addr=0 be=ff data=4444444444444444",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        tick;
        vectors++;
        if ({done_o, wr_en_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_done: got done=%b en=%b, want 1 0", done_o, wr_en_o);
        end
        tick;
        vectors++;
        if ({done_o, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_start_ignored: got done=%b busy=%b, want 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_reset_mid;
        do_start(5'd12, 4'd4, 2'd0, 7'd32, 1'b1, 64'h0, 1'b0);
        beat(64'h5555555555555555, 64'h0);
        beat(64'h6666666666666666, 64'h0);
        vectors++;
        if ({wr_en_o, wr_addr_o} !== {1'b1, 5'd13}) begin
            miscompares++;
            $display("FAIL midreset_prewrite: got en=%b addr=%0d, want en=1 addr=13", wr_en_o, wr_addr_o);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_data_o, wr_be_o, busy_o, done_o} !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: got en=%b addr=%0d data=%h be=%h busy=%b done=%b, want all 0",
                     wr_en_o, wr_addr_o, wr_data_o, wr_be_o, busy_o, done_o);
        end
        tick;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if ({done_o, busy_o, wr_en_o} !== 3'b000) begin
                miscompares++;
                $display("FAIL midreset_abandon%0d: got done=%b busy=%b en=%b, want 0 0 0", i, done_o, busy_o, wr_en_o);
            end
        end
        do_start(5'd20, 4'd1, 2'd2, 7'd2, 1'b1, 64'h0, 1'b0);
        beat(64'h7777777777777777, 64'h0);
        vectors++;
        if ({wr_en_o, wr_addr_o, wr_be_o} !== {1'b1, 5'd20, 8'hFF} || wr_data_o !== 64'h7777777777777777) begin
            miscompares++;
            $display("FAIL midreset_restart: got en=%b addr=%0d be=%h data=%h, want en=1 addr=20 be=ff data=7777777777777777",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        tick;
        vectors++;
        if (done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_restart_done: got done=%b, want 1", done_o);
        end
        tick;
    endtask

    initial begin
        start_i = 1'b0; vd_i = '0; nregs_i = 4'd1; vsew_i = '0; vl_i = '0; vm_i = 1'b1;
        mask_i = '0; mask_result_i = 1'b0; result_valid_i = 1'b0; hold_i = 1'b0;
        result_i = '0; result_mask_i = '0; reset_n = 1'b0;
        test_reset;
        test_basic;
        test_sew16;
        test_hold;
        test_masked;
        test_mask_result;
        test_vl_zero;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
